// File: rtl/capture_seq_checker.sv
// Passive checker for the source_hfifo_sink capture stream: verifies an incrementing
// sequence (mod 2^WIDTH, step STEP) and reports counts, first-mismatch details and stalls.
module capture_seq_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned STEP    = 1,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             captured_data_valid,
  input  logic [WIDTH-1:0] captured_data,
  input  logic             clear,
  output logic             locked,
  output logic [CNT_W-1:0] beat_count,
  output logic [CNT_W-1:0] err_count,
  output logic             error,
  output logic [WIDTH-1:0] first_err_got,
  output logic [WIDTH-1:0] first_err_exp,
  output logic             stall
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_expected;
  logic [IDLE_W-1:0]  r_idle;
  logic [CNT_W-1:0]   r_beat_count;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_error;
  logic [WIDTH-1:0]   r_first_err_got;
  logic [WIDTH-1:0]   r_first_err_exp;
  logic               r_stall;

  logic [WIDTH-1:0]   w_next_exp;
  logic               w_match;
  logic               w_beat_sat;
  logic               w_err_sat;
  logic               w_idle_full;
  logic               w_idle_last;

  // Matching and resync both expect data+STEP next, so one adder serves every case.
  assign w_next_exp  = captured_data + WIDTH'(STEP);
  assign w_match     = (captured_data == r_expected);
  assign w_beat_sat  = (r_beat_count == {CNT_W{1'b1}});
  assign w_err_sat   = (r_err_count == {CNT_W{1'b1}});
  assign w_idle_full = (r_idle == IDLE_W'(TIMEOUT));
  assign w_idle_last = (r_idle == IDLE_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state         <= ST_UNLOCKED;
      r_expected      <= '0;
      r_idle          <= '0;
      r_beat_count    <= '0;
      r_err_count     <= '0;
      r_error         <= 1'b0;
      r_first_err_got <= '0;
      r_first_err_exp <= '0;
      r_stall         <= 1'b0;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (captured_data_valid) begin
            r_state      <= ST_LOCKED;
            r_beat_count <= CNT_W'(1);
            r_expected   <= w_next_exp;
            r_idle       <= '0;
          end
        end
        ST_LOCKED: begin
          if (captured_data_valid) begin
            r_idle     <= '0;
            r_expected <= w_next_exp;
            if (!w_beat_sat) r_beat_count <= r_beat_count + CNT_W'(1);
            if (!w_match) begin
              if (!w_err_sat) r_err_count <= r_err_count + CNT_W'(1);
              if (!r_error) begin
                r_error         <= 1'b1;
                r_first_err_got <= captured_data;
                r_first_err_exp <= r_expected;
              end
            end
          end else if (!w_idle_full) begin
            // Counter parks at TIMEOUT once reached; stall is sticky from then on.
            r_idle <= r_idle + IDLE_W'(1);
            if (w_idle_last) r_stall <= 1'b1;
          end
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

  assign locked        = (r_state == ST_LOCKED);
  assign beat_count    = r_beat_count;
  assign err_count     = r_err_count;
  assign error         = r_error;
  assign first_err_got = r_first_err_got;
  assign first_err_exp = r_first_err_exp;
  assign stall         = r_stall;

endmodule

// File: tb/tb_capture_seq_checker.sv
// Directed bench for capture_seq_checker; a CNT_W=4 copy shares the stimulus for saturation.
module tb_capture_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        captured_data_valid;
  logic [7:0]  captured_data;

  logic        locked;
  logic [15:0] beat_count;
  logic [15:0] err_count;
  logic        error;
  logic [7:0]  first_err_got;
  logic [7:0]  first_err_exp;
  logic        stall;

  logic        s_locked;
  logic [3:0]  s_beat_count;
  logic [3:0]  s_err_count;
  logic        s_error;
  logic [7:0]  s_first_err_got;
  logic [7:0]  s_first_err_exp;
  logic        s_stall;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  capture_seq_checker #(.WIDTH(8), .STEP(1), .CNT_W(16), .TIMEOUT(256)) dut (
    .clk(clk), .rst(rst), .captured_data_valid(captured_data_valid),
    .captured_data(captured_data), .clear(clear), .locked(locked),
    .beat_count(beat_count), .err_count(err_count), .error(error),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp), .stall(stall)
  );

  capture_seq_checker #(.WIDTH(8), .STEP(1), .CNT_W(4), .TIMEOUT(256)) dut_small (
    .clk(clk), .rst(rst), .captured_data_valid(captured_data_valid),
    .captured_data(captured_data), .clear(clear), .locked(s_locked),
    .beat_count(s_beat_count), .err_count(s_err_count), .error(s_error),
    .first_err_got(s_first_err_got), .first_err_exp(s_first_err_exp), .stall(s_stall)
  );

  // One clock: inputs held across the posedge, outputs sampled 1 time unit later.
  task automatic step(input logic v, input logic [7:0] d);
    captured_data_valid = v;
    captured_data       = d;
    @(posedge clk);
    #1;
    captured_data_valid = 1'b0;
    captured_data       = 8'hA5;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h5A);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, 8'h00);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 8'h33);
    step(1'b0, 8'h00);
    rst = 1'b0;
    tests++;
    if ({locked, beat_count, err_count, error, first_err_got, first_err_exp, stall} !== 52'd0) begin
      failed++;
      $display("FAIL reset_outputs got locked=%0b beats=%0d errs=%0d error=%0b got=%h exp=%h stall=%0b required all zero",
               locked, beat_count, err_count, error, first_err_got, first_err_exp, stall);
    end
    idle(5);
    tests++;
    if (stall !== 1'b0 || locked !== 1'b0) begin
      failed++;
      $display("FAIL reset_idle_unlocked got stall=%0b locked=%0b required 0 0", stall, locked);
    end
  endtask

  task automatic test_basic_stream();
    step(1'b1, 8'h00);
    tests++;
    if (locked !== 1'b1 || beat_count !== 16'd1) begin
      failed++;
      $display("FAIL first_beat_latency got locked=%0b beats=%0d required 1 1", locked, beat_count);
    end
    for (int i = 1; i < 20; i++) step(1'b1, 8'(i));
    tests++;
    if (locked !== 1'b1 || beat_count !== 16'd20 || err_count !== 16'd0 || error !== 1'b0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL basic_stream got locked=%0b beats=%0d errs=%0d error=%0b stall=%0b required 1 20 0 0 0",
               locked, beat_count, err_count, error, stall);
    end
  endtask

  task automatic test_wrap_gaps();
    logic [7:0] vals [5] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    do_clear();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vals[i]);
      idle(i % 4);
    end
    tests++;
    if (beat_count !== 16'd5 || err_count !== 16'd0 || error !== 1'b0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL wrap_gaps got beats=%0d errs=%0d error=%0b stall=%0b required 5 0 0 0",
               beat_count, err_count, error, stall);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] vals [5] = '{8'h10, 8'h11, 8'h15, 8'h16, 8'h20};
    do_clear();
    for (int i = 0; i < 3; i++) step(1'b1, vals[i]);
    tests++;
    if (error !== 1'b1 || err_count !== 16'd1 || first_err_got !== 8'h15 || first_err_exp !== 8'h12) begin
      failed++;
      $display("FAIL first_mismatch got error=%0b errs=%0d got=%h exp=%h required 1 1 15 12",
               error, err_count, first_err_got, first_err_exp);
    end
    for (int i = 3; i < 5; i++) step(1'b1, vals[i]);
    tests++;
    if (err_count !== 16'd2 || error !== 1'b1 || first_err_got !== 8'h15 ||
        first_err_exp !== 8'h12 || beat_count !== 16'd5) begin
      failed++;
      $display("FAIL mismatch_totals got errs=%0d error=%0b got=%h exp=%h beats=%0d required 2 1 15 12 5",
               err_count, error, first_err_got, first_err_exp, beat_count);
    end
    step(1'b1, 8'h21);
    tests++;
    if (err_count !== 16'd2) begin
      failed++;
      $display("FAIL resync_after_error got errs=%0d required 2", err_count);
    end
  endtask

  task automatic test_stall();
    do_clear();
    step(1'b1, 8'h00);
    idle(255);
    tests++;
    if (stall !== 1'b0) begin
      failed++;
      $display("FAIL stall_early got %0b required 0 after 255 idle", stall);
    end
    idle(1);
    tests++;
    if (stall !== 1'b1) begin
      failed++;
      $display("FAIL stall_at_timeout got %0b required 1 after 256 idle", stall);
    end
    step(1'b1, 8'h01);
    idle(3);
    tests++;
    if (stall !== 1'b1 || err_count !== 16'd0 || beat_count !== 16'd2) begin
      failed++;
      $display("FAIL stall_sticky got stall=%0b errs=%0d beats=%0d required 1 0 2", stall, err_count, beat_count);
    end
    do_clear();
    step(1'b1, 8'h00);
    idle(255);
    step(1'b1, 8'h01);
    idle(10);
    tests++;
    if (stall !== 1'b0) begin
      failed++;
      $display("FAIL stall_255_then_beat got %0b required 0", stall);
    end
  endtask

  task automatic test_clear_midstream();
    do_clear();
    step(1'b1, 8'h30);
    step(1'b1, 8'h35);
    clear = 1'b1;
    step(1'b1, 8'h40);
    clear = 1'b0;
    tests++;
    if (locked !== 1'b0 || beat_count !== 16'd0 || error !== 1'b0 || err_count !== 16'd0) begin
      failed++;
      $display("FAIL clear_drops_beat got locked=%0b beats=%0d error=%0b errs=%0d required 0 0 0 0",
               locked, beat_count, error, err_count);
    end
    step(1'b1, 8'h77);
    tests++;
    if (beat_count !== 16'd1 || err_count !== 16'd0 || error !== 1'b0 || locked !== 1'b1) begin
      failed++;
      $display("FAIL clear_relock got beats=%0d errs=%0d error=%0b locked=%0b required 1 0 0 1",
               beat_count, err_count, error, locked);
    end
    rst = 1'b1;
    clear = 1'b0;
    step(1'b1, 8'h78);
    rst = 1'b0;
    tests++;
    if (locked !== 1'b0 || beat_count !== 16'd0) begin
      failed++;
      $display("FAIL rst_drops_beat got locked=%0b beats=%0d required 0 0", locked, beat_count);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 20; i++) step(1'b1, 8'h00);
    tests++;
    if (s_err_count !== 4'hF || s_beat_count !== 4'hF) begin
      failed++;
      $display("FAIL small_saturate got errs=%h beats=%h required f f", s_err_count, s_beat_count);
    end
    tests++;
    if (err_count !== 16'd19 || beat_count !== 16'd20 || first_err_got !== 8'h00 || first_err_exp !== 8'h01) begin
      failed++;
      $display("FAIL wide_counts got errs=%0d beats=%0d got=%h exp=%h required 19 20 00 01",
               err_count, beat_count, first_err_got, first_err_exp);
    end
  endtask

  task automatic test_random_gating();
    int         n_beats = 0;
    logic [7:0] d = 8'($urandom_range(0, 255));
    do_clear();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        step(1'b1, d);
        d = d + 8'd1;
        n_beats++;
      end else begin
        step(1'b0, 8'($urandom_range(0, 255)));
      end
    end
    tests++;
    if (beat_count !== 16'(n_beats) || err_count !== 16'd0 || error !== 1'b0 || stall !== 1'b0) begin
      failed++;
      $display("FAIL random_gating got beats=%0d errs=%0d error=%0b stall=%0b required %0d 0 0 0",
               beat_count, err_count, error, stall, n_beats);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    captured_data_valid = 1'b0;
    captured_data = 8'h00;
    test_reset();
    test_basic_stream();
    test_wrap_gaps();
    test_mismatch();
    test_stall();
    test_clear_midstream();
    test_saturation();
    test_random_gating();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
